// File: rtl/mux_n_buf.sv
// mux_n_buf: NUM-to-1 channel select feeding a 2-entry FIFO with valid/ready handshake.
// Optional macro MUX_N_BUF_SEL_CHECK_EN: out-of-range selects store 0 and raise a sticky sel_err.
module mux_n_buf #(
    parameter int WIDTH = 32,
    parameter int NUM   = 4,
    parameter int SEL_W = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM*WIDTH-1:0]   in_data,
    input  logic [SEL_W-1:0]       sel,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   flush,
    output logic                   sel_err
);

    localparam int SLOTS = 1 << SEL_W;
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] chan_s [SLOTS];
    logic [WIDTH-1:0] fallback_s;
    logic [WIDTH-1:0] sel_data_s;
    logic [1:0]       count_r;
    logic [1:0]       count_s;
    logic [WIDTH-1:0] head_r;
    logic [WIDTH-1:0] head_s;
    logic [WIDTH-1:0] tail_r;
    logic [WIDTH-1:0] tail_s;
    logic             push_s;
    logic             pop_s;

`ifdef MUX_N_BUF_SEL_CHECK_EN
    logic sel_oor_s;
    logic sel_err_r;
    logic sel_err_s;

    assign fallback_s = ZERO;
    assign sel_oor_s  = ({1'b0, sel} >= (SEL_W+1)'(NUM));
    assign sel_err    = sel_err_r;

    // Sticky out-of-range flag; flush wins over a simultaneous bad accept.
    always_comb begin
        sel_err_s = sel_err_r;
        if (flush) begin
            sel_err_s = 1'b0;
        end else if (push_s && sel_oor_s) begin
            sel_err_s = 1'b1;
        end else begin
            sel_err_s = sel_err_r;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err_r <= 1'b0;
        end else begin
            sel_err_r <= sel_err_s;
        end
    end
`else
    assign fallback_s = in_data[WIDTH-1:0];
    assign sel_err    = 1'b0;
`endif

    // Unused select codes beyond NUM map onto the fallback value.
    for (genvar k = 0; k < SLOTS; k++) begin : g_chan
        if (k < NUM) begin : g_in
            assign chan_s[k] = in_data[k*WIDTH +: WIDTH];
        end else begin : g_oor
            assign chan_s[k] = fallback_s;
        end
    end

    assign sel_data_s = chan_s[sel];
    assign in_ready   = (count_r != 2'd2);
    assign out_valid  = (count_r != 2'd0);
    assign out_data   = head_r;
    assign push_s     = in_valid && in_ready;
    assign pop_s      = out_valid && out_ready;

    // Next buffer state; empty slots are kept at zero so head_r drives out_data directly.
    always_comb begin
        count_s = count_r;
        head_s  = head_r;
        tail_s  = tail_r;
        if (flush) begin
            count_s = 2'd0;
            head_s  = ZERO;
            tail_s  = ZERO;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_s = sel_data_s;
                    end else begin
                        tail_s = sel_data_s;
                    end
                    count_s = count_r + 2'd1;
                end
                2'b01: begin
                    head_s  = tail_r;
                    tail_s  = ZERO;
                    count_s = count_r - 2'd1;
                end
                2'b11: begin
                    head_s = sel_data_s;
                end
                default: begin
                    count_s = count_r;
                end
            endcase
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 2'd0;
            head_r  <= ZERO;
            tail_r  <= ZERO;
        end else begin
            count_r <= count_s;
            head_r  <= head_s;
            tail_r  <= tail_s;
        end
    end

endmodule

// File: tb/tb_mux_n_buf.sv
// Randomized self-checking bench for mux_n_buf against a queue-based reference model.
// A second NUM=3 instance exercises out-of-range select handling.
module tb_mux_n_buf;

    localparam int WIDTH = 32;
    localparam int NUM   = 4;
    localparam int SEL_W = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM*WIDTH-1:0] in_data = '0;
    logic [SEL_W-1:0]     sel = '0;
    logic                 in_valid = 1'b0;
    logic                 out_ready = 1'b0;
    logic                 flush = 1'b0;
    logic                 in_ready;
    logic                 out_valid;
    logic                 sel_err;
    logic [WIDTH-1:0]     out_data;

    logic [3*WIDTH-1:0]   in_data3 = '0;
    logic [1:0]           sel3 = '0;
    logic                 in_valid3 = 1'b0;
    logic                 out_ready3 = 1'b0;
    logic                 flush3 = 1'b0;
    logic                 in_ready3;
    logic                 out_valid3;
    logic                 sel_err3;
    logic [WIDTH-1:0]     out_data3;

    logic [WIDTH-1:0] q[$];
    logic             err_m = 1'b0;
    int               n_tests = 0;
    int               n_fail = 0;

    always #5 clk = ~clk;

    mux_n_buf #(.WIDTH(WIDTH), .NUM(NUM), .SEL_W(SEL_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel), .in_valid(in_valid),
        .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .flush(flush), .sel_err(sel_err)
    );

    mux_n_buf #(.WIDTH(WIDTH), .NUM(3), .SEL_W(2)) dut3 (
        .clk(clk), .rst_n(rst_n), .in_data(in_data3), .sel(sel3), .in_valid(in_valid3),
        .in_ready(in_ready3), .out_data(out_data3), .out_valid(out_valid3),
        .out_ready(out_ready3), .flush(flush3), .sel_err(sel_err3)
    );

    task automatic chk(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: 2-deep queue; acceptance judged on occupancy before the edge.
    task automatic model_edge();
        bit acc;
        bit pp;
        if (!rst_n || flush) begin
            q.delete();
            err_m = 1'b0;
        end else begin
            acc = in_valid && (q.size() < 2);
            pp  = out_ready && (q.size() > 0);
            if (pp) void'(q.pop_front());
            if (acc) q.push_back(in_data[int'(sel)*WIDTH +: WIDTH]);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"}, WIDTH'(out_valid), WIDTH'(q.size() > 0));
        chk({tag, ".out_data"}, out_data, (q.size() > 0) ? q[0] : '0);
        chk({tag, ".in_ready"}, WIDTH'(in_ready), WIDTH'(q.size() < 2));
        chk({tag, ".sel_err"}, WIDTH'(sel_err), WIDTH'(err_m));
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_outputs(tag);
    endtask

    initial begin
        #12;
        check_outputs("in_reset");
        @(negedge clk);
        rst_n = 1'b1;
        cycle("after_reset");

        in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};

        // single transfer through the buffer
        sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
        cycle("one_push");
        chk("one_push.data", out_data, 32'h33333333);
        in_valid = 1'b0;
        cycle("one_pop");
        chk("one_pop.valid", WIDTH'(out_valid), '0);

        // fill to two, third offer refused, drain in order
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
        cycle("fill0");
        sel = 2'd1;
        cycle("fill1");
        chk("full.in_ready", WIDTH'(in_ready), '0);
        sel = 2'd3;
        cycle("fill_refused");
        in_valid = 1'b0; out_ready = 1'b1;
        chk("drain.first", out_data, 32'h11111111);
        cycle("drain1");
        chk("drain.second", out_data, 32'h22222222);
        cycle("drain2");
        chk("drain.empty", WIDTH'(out_valid), '0);

        // push and pop together at count 1
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd1;
        cycle("pp_setup");
        sel = 2'd3; out_ready = 1'b1;
        cycle("pp");
        chk("pp.data", out_data, 32'h44444444);
        chk("pp.count1", WIDTH'(in_ready), 32'd1);
        in_valid = 1'b0;
        cycle("pp_drain");

        // flush at count 2 overrides an offered push
        out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
        cycle("fl0");
        sel = 2'd1;
        cycle("fl1");
        flush = 1'b1; sel = 2'd0;
        cycle("flush");
        chk("flush.valid", WIDTH'(out_valid), '0);
        chk("flush.in_ready", WIDTH'(in_ready), 32'd1);
        flush = 1'b0; in_valid = 1'b0;
        cycle("post_flush");

        // randomized traffic with a mid-run asynchronous reset
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < NUM; k++) in_data[k*WIDTH +: WIDTH] = $urandom();
            sel       = SEL_W'($urandom_range(0, NUM - 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            if (i == 200) begin
                in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
                cycle("pre_rst");
                #2;
                rst_n = 1'b0;
                q.delete();
                err_m = 1'b0;
                #1;
                check_outputs("async_rst");
                @(negedge clk);
                rst_n = 1'b1;
            end
            cycle("rand");
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;

        // NUM=3 instance, select 3 is out of range
        in_data3 = {32'h33333333, 32'h22222222, 32'h11111111};
        sel3 = 2'd3; in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        chk("oor.valid", WIDTH'(out_valid3), 32'd1);
`ifdef MUX_N_BUF_SEL_CHECK_EN
        chk("oor.data", out_data3, 32'h00000000);
        chk("oor.err", WIDTH'(sel_err3), 32'd1);
        @(posedge clk); #1;
        chk("oor.err_sticky", WIDTH'(sel_err3), 32'd1);
`else
        chk("oor.data", out_data3, 32'h11111111);
        chk("oor.err", WIDTH'(sel_err3), 32'd0);
        @(posedge clk); #1;
        chk("oor.err_stays0", WIDTH'(sel_err3), 32'd0);
`endif
        flush3 = 1'b1;
        @(posedge clk); #1;
        flush3 = 1'b0;
        chk("oor.flush_err", WIDTH'(sel_err3), 32'd0);
        chk("oor.flush_valid", WIDTH'(out_valid3), 32'd0);
        chk("oor.flush_ready", WIDTH'(in_ready3), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_n_buf.md
MUX_N_BUF -- requirements
Module: mux_n_buf

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data width of each input channel and of the output.
REQ-002 SHALL have parameter NUM, default 4, number of input channels (2..16).
REQ-003 SHALL have parameter SEL_W, default 2, select width; it SHALL satisfy 2^SEL_W >= NUM.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port in_data  input  NUM*WIDTH  flattened channels; channel k at bits [k*WIDTH +: WIDTH].
REQ-007 SHALL have port sel  input  SEL_W  channel select, sampled on accept.
REQ-008 SHALL have port in_valid  input  1  producer offers a selection this cycle.
REQ-009 SHALL have port in_ready  output  1  block can accept this cycle.
REQ-010 SHALL have port out_data  output  WIDTH  head-of-buffer data.
REQ-011 SHALL have port out_valid  output  1  out_data is valid.
REQ-012 SHALL have port out_ready  input  1  consumer takes head this cycle.
REQ-013 SHALL have port flush  input  1  synchronous discard of all buffered entries.
REQ-014 SHALL have port sel_err  output  1  sticky out-of-range select flag.

Function
REQ-015 Accept SHALL occur when in_valid && in_ready; the selected channel slice at sel is written to the buffer tail.
REQ-016 Pop SHALL occur when out_valid && out_ready; the head entry is removed.
REQ-017 Buffer SHALL hold 2 entries; occupancy count 0..2; FIFO order preserved.
REQ-018 in_ready SHALL equal (count != 2), decoded from registered state only; no combinational path from out_ready.
REQ-019 out_valid SHALL equal (count != 0); out_data SHALL be the head entry, 0 when count == 0.
REQ-020 Latency SHALL be 1 cycle: data accepted at edge N is on out_data with out_valid = 1 after edge N.
REQ-021 Push and pop in same cycle at count 1 SHALL leave count 1 with the new entry at head.
REQ-022 At count 2, no push SHALL occur (in_ready = 0); a pop SHALL reduce count to 1.
REQ-023 At count 0, out_ready SHALL be ignored; no underflow.
REQ-024 flush SHALL set count to 0 at the next edge and SHALL override any simultaneous push or pop (flushed-cycle input is discarded).
REQ-025 flush SHALL clear sel_err.
REQ-026 Selected data SHALL be passed bit-exact, no width change.

Reset
REQ-027 rst_n low SHALL immediately force count = 0, all entries = 0, sel_err = 0, independent of clk.
REQ-028 During and after reset: out_valid = 0, out_data = 0, in_ready = 1.
REQ-029 Reset asserted mid-transfer SHALL discard all buffered entries; no partial state survives.

Configuration
REQ-030 Macro MUX_N_BUF_SEL_CHECK_EN SHALL control out-of-range select handling.
REQ-031 With MUX_N_BUF_SEL_CHECK_EN defined: accept with sel >= NUM SHALL store 0 and set sel_err = 1 at the next edge (sticky until flush or reset).
REQ-032 Without MUX_N_BUF_SEL_CHECK_EN: accept with sel >= NUM SHALL store channel 0 data; sel_err SHALL be tied 0.

Verification (WIDTH=32, NUM=4, SEL_W=2 unless noted)
REQ-033 Reset release, idle inputs -> out_valid=0, out_data=0, in_ready=1, sel_err=0.
REQ-034 Channels 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444; sel=2, in_valid=1 one cycle, out_ready=1 -> next cycle out_data=0x33333333, out_valid=1, then out_valid=0.
REQ-035 out_ready=0, three accepts sel=0,1,3 -> third not accepted (in_ready=0 after 2); then out_ready=1 -> outputs 0x11111111, 0x22222222 in order, count 0.
REQ-036 count=1 (head 0x22222222), push sel=3 with out_ready=1 -> next cycle out_data=0x44444444, count 1.
REQ-037 count=2, flush=1 with in_valid=1 sel=0 -> next cycle out_valid=0, in_ready=1, nothing stored.
REQ-038 NUM=3 with MUX_N_BUF_SEL_CHECK_EN: accept sel=3 -> out_data=0, sel_err=1 until flush; without macro -> out_data=channel 0 value, sel_err=0.
